// File: rtl/display_timing_pkg.sv
// Shared timing types and standard video modes for the display timing generator.
package display_timing_pkg;

    typedef struct packed {
        int res;
        int fp;
        int sync;
        int bp;
    } timing_t;

    typedef struct packed {
        timing_t h;
        timing_t v;
    } video_mode_t;

    localparam video_mode_t TIMING_480P60 = '{'{640, 16, 96, 48}, '{480, 10, 2, 33}};
    localparam video_mode_t TIMING_720P60 = '{'{1280, 110, 40, 220}, '{720, 5, 5, 20}};

    function automatic int timing_total(timing_t t);
        return t.res + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/display_timing_axis.sv
// One wrapping position counter with registered sync and active decode, used once per axis.
module display_timing_axis
    import display_timing_pkg::*;
#(
    parameter int CORDW = 10,
    parameter int RES   = 640,
    parameter int FP    = 16,
    parameter int SYNC  = 96,
    parameter int BP    = 48,
    parameter bit POL   = 1'b0
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic             step,
    output logic [CORDW-1:0] pos,
    output logic             last,
    output logic             sync,
    output logic             active
);

    localparam timing_t T = '{res: RES, fp: FP, sync: SYNC, bp: BP};
    localparam logic [CORDW-1:0] POS_LAST = CORDW'(timing_total(T) - 1);
    localparam logic [CORDW-1:0] SYNC_BEG = CORDW'(RES + FP);
    localparam logic [CORDW-1:0] SYNC_END = CORDW'(RES + FP + SYNC);
    localparam logic [CORDW-1:0] ACT_END  = CORDW'(RES);

    logic [CORDW-1:0] pos_next;

    assign last = (pos == POS_LAST);

    always_comb begin
        pos_next = pos;
        if (step) begin
            pos_next = last ? '0 : pos + CORDW'(1);
        end
    end

    // Decode from pos_next so sync/active line up with the position they describe.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            pos    <= '0;
            sync   <= ~POL;
            active <= 1'b1;
        end else if (step) begin
            pos    <= pos_next;
            sync   <= (pos_next >= SYNC_BEG && pos_next < SYNC_END) ? POL : ~POL;
            active <= (pos_next < ACT_END);
        end
    end

endmodule

// File: rtl/display_timing.sv
// Display timing generator: sx/sy counters, syncs, data enable and frame/line strobes.
// Optional frame_cnt output when DISPLAY_TIMING_FRAME_CNT_EN is defined.
module display_timing
    import display_timing_pkg::*;
#(
    parameter int CORDW  = 10,
    parameter int H_RES  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_RES  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter bit H_POL  = 1'b0,
    parameter bit V_POL  = 1'b0
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic             en,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame,
    output logic             line
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam timing_t H_T = '{res: H_RES, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_t V_T = '{res: V_RES, fp: V_FP, sync: V_SYNC, bp: V_BP};

    if (H_RES <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_RES <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_zero_param
        $error("display_timing: every timing parameter must be non-zero");
    end

    if (longint'(timing_total(H_T)) > (longint'(1) << CORDW) ||
        longint'(timing_total(V_T)) > (longint'(1) << CORDW)) begin : g_cordw_small
        $error("display_timing: CORDW too narrow for line or frame total");
    end

    logic h_last;
    logic v_last;
    logic h_active;
    logic v_active;

    display_timing_axis #(
        .CORDW (CORDW),
        .RES   (H_RES),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .BP    (H_BP),
        .POL   (H_POL)
    ) u_h_axis (
        .clk_pix (clk_pix),
        .rst     (rst),
        .step    (en),
        .pos     (sx),
        .last    (h_last),
        .sync    (hsync),
        .active  (h_active)
    );

    display_timing_axis #(
        .CORDW (CORDW),
        .RES   (V_RES),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .BP    (V_BP),
        .POL   (V_POL)
    ) u_v_axis (
        .clk_pix (clk_pix),
        .rst     (rst),
        .step    (en & h_last),
        .pos     (sy),
        .last    (v_last),
        .sync    (vsync),
        .active  (v_active)
    );

    assign de = h_active & v_active;

    // The next position is (0, y) exactly when the current advance wraps the line.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            line  <= 1'b1;
            frame <= 1'b1;
        end else if (en) begin
            line  <= h_last;
            frame <= h_last & v_last;
        end
    end

`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (en && h_last && v_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/display_timing.md
DISPLAY_TIMING -- requirements
Module: display_timing

Interface
REQ-001 Parameter CORDW, default 10: width of the sx and sy coordinate outputs.
REQ-002 Parameter H_RES, default 640: active pixels per line.
REQ-003 Parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-004 Parameter H_SYNC, default 96: horizontal sync width, in pixels.
REQ-005 Parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-006 Parameter V_RES, default 480: active lines per frame.
REQ-007 Parameter V_FP, default 10: vertical front porch, in lines.
REQ-008 Parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-009 Parameter V_BP, default 33: vertical back porch, in lines.
REQ-010 Parameter H_POL, default 0: hsync asserted level (0 = active low, 1 = active high).
REQ-011 Parameter V_POL, default 0: vsync asserted level (0 = active low, 1 = active high).
REQ-012 Port clk_pix, input, 1 bit: pixel clock, the only clock.
REQ-013 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-014 Port en, input, 1 bit: pixel-advance enable.
REQ-015 Port sx, output, CORDW bits: current horizontal position.
REQ-016 Port sy, output, CORDW bits: current vertical position.
REQ-017 Port hsync, output, 1 bit: horizontal sync, polarity set by H_POL.
REQ-018 Port vsync, output, 1 bit: vertical sync, polarity set by V_POL.
REQ-019 Port de, output, 1 bit: data enable, high in the active area.
REQ-020 Port frame, output, 1 bit: one-pixel strobe at sx=0, sy=0.
REQ-021 Port line, output, 1 bit: one-pixel strobe at sx=0 on every line.

Function
REQ-022 Line and frame totals SHALL be H_TOT = H_RES+H_FP+H_SYNC+H_BP and V_TOT = V_RES+V_FP+V_SYNC+V_BP.
REQ-023 Counters SHALL advance only when en=1: sx increments by 1; at sx=H_TOT-1, sx wraps to 0 and sy increments; at sy=V_TOT-1 with sx=H_TOT-1, sy wraps to 0.
REQ-024 With en=0, sx, sy and all other outputs SHALL hold their values.
REQ-025 hsync SHALL be at the asserted level exactly for H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC, and at the opposite level otherwise.
REQ-026 vsync SHALL be at the asserted level exactly for V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC, and at the opposite level otherwise.
REQ-027 de SHALL be 1 exactly when sx < H_RES and sy < V_RES.
REQ-028 hsync, vsync, de, frame and line SHALL be registered, computed from the next counter value, so each is cycle-aligned with the sx/sy it describes.
REQ-029 Outputs SHALL have no combinational path from any input.
REQ-030 Strobes SHALL last one cycle; if en=0 on the following cycle, a strobe SHALL stay high until the next advance.
REQ-031 All comparisons SHALL be unsigned at CORDW width.
REQ-032 Elaboration SHALL fail via $error if H_TOT-1 or V_TOT-1 exceeds 2**CORDW-1.
REQ-033 Elaboration SHALL fail via $error if any timing parameter is 0.

Reset
REQ-034 While rst=1 (sampled at the clk_pix edge), the block SHALL load sx=0, sy=0, de=1, frame=1, line=1, and hsync/vsync at their deasserted levels; this SHALL hold regardless of en and of the frame position.
REQ-035 On the first clock with rst=0 and en=1, the block SHALL advance to sx=1 with frame=0 and line=0.

Configuration
REQ-036 Macro DISPLAY_TIMING_FRAME_CNT_EN, when defined, SHALL add output frame_cnt (16 bits).
REQ-037 frame_cnt SHALL reset to 0, increment (wrapping at 65535) on each frame wrap, and be aligned with frame.
REQ-038 Without DISPLAY_TIMING_FRAME_CNT_EN, neither the port frame_cnt nor its logic SHALL exist.

Structure
REQ-039 Package display_timing_pkg SHALL hold typedef timing_t, a struct of res/fp/sync/bp.
REQ-040 Package display_timing_pkg SHALL hold constants TIMING_480P60 and TIMING_720P60.
REQ-041 Package display_timing_pkg SHALL hold function timing_total().
REQ-042 One sub-module, display_timing_axis, SHALL implement a single wrapping counter with sync and active decode; it SHALL be instantiated once for horizontal and once for vertical, with the vertical step gated by the horizontal wrap.

Verification
REQ-043 Defaults, en=1, 2 frames -> frame pulses exactly 420000 cycles apart; line pulses every 800 cycles; de high for 307200 cycles per frame.
REQ-044 Defaults -> hsync=0 exactly for sx 656..751; vsync=0 exactly for sy 490..491; sx max 799; sy max 524.
REQ-045 H_POL=1, V_POL=1, 1280x720 (110/40/220, 5/5/20), CORDW=11 -> hsync=1 for sx 1390..1429; frame period 1650x750 cycles.
REQ-046 en toggled 1/0 alternately -> one full frame takes 840000 cycles; outputs stable on every en=0 cycle.
REQ-047 rst=1 asserted at sx=700, sy=300 -> next cycle sx=0, sy=0, frame=1; with rst then released and en=1, sx=1 on the following cycle.
REQ-048 DISPLAY_TIMING_FRAME_CNT_EN defined, 3 frames run -> frame_cnt sequence 0,1,2,3, each step on a frame strobe.
